// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : noc_pkg
//  Brief    : Router-wide constants, index types and pointer-advance helpers
//  Revision : 1.0
// ============================================================================
package noc_pkg;

    localparam int PORT_NUM     = 5;
    localparam int VC_NUM       = 2;
    localparam int BUFFER_DEPTH = 4;

    localparam int c_cnt_w = $clog2(BUFFER_DEPTH + 1);

    typedef logic [$clog2(PORT_NUM)-1:0] port_t;
    typedef logic [$clog2(VC_NUM)-1:0]   vc_t;
    typedef logic [c_cnt_w-1:0]          cnt_t;

    function automatic port_t next_port(input port_t p);
        return (p == port_t'(PORT_NUM - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic vc_t next_vc(input vc_t v);
        return (v == vc_t'(VC_NUM - 1)) ? '0 : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin pick; search starts at i_ptr, wraps
//  Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    logic w_found;

    // Two passes: first the slots at or above the pointer, then the wrapped ones.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!w_found && i_req[j] && (j >= int'(i_ptr))) begin
                w_found  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!w_found && i_req[j] && (j < int'(i_ptr))) begin
                w_found  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : switch_allocator
//  Brief    : Separable input-first switch allocator with downstream credits
//  Revision : 1.0
// ============================================================================
module switch_allocator
    import noc_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0] req_i,
    input  port_t [PORT_NUM-1:0][VC_NUM-1:0] req_port_i,
    input  logic  [PORT_NUM-1:0]             credit_i,
    output logic  [PORT_NUM-1:0][VC_NUM-1:0] grant_o,
    output port_t [PORT_NUM-1:0]             input_vc_sel_o,
    output logic  [PORT_NUM-1:0]             valid_o,
    output logic                             credit_err_o
);

    logic  [PORT_NUM-1:0][VC_NUM-1:0]   w_elig;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]   w_vc_gnt;
    vc_t   [PORT_NUM-1:0]               w_nom_vc;
    logic  [PORT_NUM-1:0]               w_nom_vld;
    port_t [PORT_NUM-1:0]               w_nom_port;
    logic  [PORT_NUM-1:0][PORT_NUM-1:0] w_out_req;   // [output][input]
    logic  [PORT_NUM-1:0][PORT_NUM-1:0] w_in_gnt;    // [output][input]
    port_t [PORT_NUM-1:0]               w_win;
    logic  [PORT_NUM-1:0]               w_won;
    logic  [PORT_NUM-1:0]               w_has_credit;

    vc_t   [PORT_NUM-1:0]               r_vc_ptr;
    port_t [PORT_NUM-1:0]               r_in_ptr;
    cnt_t  [PORT_NUM-1:0]               r_credit;
    logic                               r_credit_err;

    always_comb begin
        w_has_credit = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            w_has_credit[o] = (r_credit[o] != '0);
        end
    end

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                w_elig[i][v] = req_i[i][v] && (int'(req_port_i[i][v]) < PORT_NUM)
                             && w_has_credit[req_port_i[i][v]];
            end
        end
    end

    // Stage 1: each input nominates one eligible VC.
    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_vc_arb
        rr_arbiter #(
            .N     (VC_NUM),
            .IDX_W ($bits(vc_t))
        ) u_vc_arb (
            .i_req (w_elig[gi]),
            .i_ptr (r_vc_ptr[gi]),
            .o_gnt (w_vc_gnt[gi]),
            .o_idx (w_nom_vc[gi])
        );
        assign w_nom_vld[gi]  = |w_elig[gi];
        assign w_nom_port[gi] = req_port_i[gi][w_nom_vc[gi]];
    end

    always_comb begin
        w_out_req = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                w_out_req[o][i] = w_nom_vld[i] && (w_nom_port[i] == port_t'(o));
            end
        end
    end

    // Stage 2: each output picks one of the nominees aimed at it.
    for (genvar go = 0; go < PORT_NUM; go++) begin : g_in_arb
        rr_arbiter #(
            .N     (PORT_NUM),
            .IDX_W ($bits(port_t))
        ) u_in_arb (
            .i_req (w_out_req[go]),
            .i_ptr (r_in_ptr[go]),
            .o_gnt (w_in_gnt[go]),
            .o_idx (w_win[go])
        );
    end

    always_comb begin
        w_won = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            w_won = w_won | w_in_gnt[o];
        end
    end

    // Outputs are masked by rst so grants vanish as soon as reset is raised.
    always_comb begin
        valid_o        = '0;
        input_vc_sel_o = '0;
        grant_o        = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            valid_o[o]        = !rst && (|w_out_req[o]);
            input_vc_sel_o[o] = valid_o[o] ? w_win[o] : '0;
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            grant_o[i] = (!rst && w_won[i]) ? w_vc_gnt[i] : '0;
        end
    end

    assign credit_err_o = r_credit_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vc_ptr     <= '0;
            r_in_ptr     <= '0;
            r_credit_err <= 1'b0;
            for (int p = 0; p < PORT_NUM; p++) begin
                r_credit[p] <= cnt_t'(BUFFER_DEPTH);
            end
        end else begin
            for (int p = 0; p < PORT_NUM; p++) begin
                if (valid_o[p]) begin
                    r_in_ptr[p] <= next_port(w_win[p]);
                end
                if (w_won[p]) begin
                    r_vc_ptr[p] <= next_vc(w_nom_vc[p]);
                end
                if (valid_o[p] && !credit_i[p]) begin
                    r_credit[p] <= r_credit[p] - 1'b1;
                end else if (!valid_o[p] && credit_i[p]) begin
                    // A credit with the counter already full means the downstream lost track.
                    if (r_credit[p] == cnt_t'(BUFFER_DEPTH)) begin
                        r_credit_err <= 1'b1;
                    end else begin
                        r_credit[p] <= r_credit[p] + 1'b1;
                    end
                end
            end
        end
    end

    for (genvar ga = 0; ga < PORT_NUM; ga++) begin : g_assert
        a_row_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_o[ga]));
        a_col_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(w_in_gnt[ga]));
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_allocator
//  Brief    : Directed bench for switch_allocator with a per-cycle reference model
//  Revision : 1.0
// ============================================================================
module tb_switch_allocator;
    import noc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic  [PORT_NUM-1:0][VC_NUM-1:0] req_i;
    port_t [PORT_NUM-1:0][VC_NUM-1:0] req_port_i;
    logic  [PORT_NUM-1:0]             credit_i;
    logic  [PORT_NUM-1:0][VC_NUM-1:0] grant_o;
    port_t [PORT_NUM-1:0]             input_vc_sel_o;
    logic  [PORT_NUM-1:0]             valid_o;
    logic                             credit_err_o;

    int checks   = 0;
    int failures = 0;

    // Reference state: plain integers following the allocation rules.
    int m_credit [PORT_NUM];
    int m_vc_ptr [PORT_NUM];
    int m_in_ptr [PORT_NUM];
    bit m_err;

    logic  [PORT_NUM-1:0][VC_NUM-1:0] e_grant;
    logic  [PORT_NUM-1:0]             e_valid;
    port_t [PORT_NUM-1:0]             e_sel;
    int e_vc  [PORT_NUM];
    int e_win [PORT_NUM];

    switch_allocator dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .req_port_i     (req_port_i),
        .credit_i       (credit_i),
        .grant_o        (grant_o),
        .input_vc_sel_o (input_vc_sel_o),
        .valid_o        (valid_o),
        .credit_err_o   (credit_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        int  nom_vc   [PORT_NUM];
        int  nom_port [PORT_NUM];
        bit  nom_ok   [PORT_NUM];
        int  v, p, i;
        e_grant = '0;
        e_valid = '0;
        e_sel   = '0;
        for (int n = 0; n < PORT_NUM; n++) begin
            nom_ok[n] = 1'b0;
            nom_vc[n] = 0;
            nom_port[n] = 0;
            for (int k = 0; k < VC_NUM; k++) begin
                v = (m_vc_ptr[n] + k) % VC_NUM;
                p = int'(req_port_i[n][v]);
                if (!nom_ok[n] && req_i[n][v] && p < PORT_NUM && m_credit[p] > 0) begin
                    nom_ok[n] = 1'b1;
                    nom_vc[n] = v;
                    nom_port[n] = p;
                end
            end
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            e_win[o] = -1;
            e_vc[o]  = 0;
            for (int k = 0; k < PORT_NUM; k++) begin
                i = (m_in_ptr[o] + k) % PORT_NUM;
                if (e_win[o] < 0 && nom_ok[i] && nom_port[i] == o) begin
                    e_win[o] = i;
                    e_vc[o]  = nom_vc[i];
                    e_valid[o] = 1'b1;
                    e_sel[o] = port_t'(i);
                    e_grant[i][nom_vc[i]] = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            e_grant = '0;
            e_valid = '0;
            e_sel   = '0;
            for (int o = 0; o < PORT_NUM; o++) e_win[o] = -1;
        end else begin
            model_eval();
        end
        check("model_valid", 32'(valid_o), 32'(e_valid));
        check("model_sel", 32'(input_vc_sel_o), 32'(e_sel));
        check("model_grant", 32'(grant_o), 32'(e_grant));
        check("model_err", 32'(credit_err_o), 32'(m_err));
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                m_credit[o] = BUFFER_DEPTH;
                m_vc_ptr[o] = 0;
                m_in_ptr[o] = 0;
            end
            m_err = 1'b0;
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (e_valid[o]) begin
                    m_in_ptr[o] = (e_win[o] + 1) % PORT_NUM;
                    m_vc_ptr[e_win[o]] = (e_vc[o] + 1) % VC_NUM;
                end
                m_credit[o] = m_credit[o] - int'(e_valid[o]) + int'(credit_i[o]);
                if (m_credit[o] > BUFFER_DEPTH) begin
                    m_credit[o] = BUFFER_DEPTH;
                    m_err = 1'b1;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_w [6] = '{0, 2, 4, 0, 2, 4};
        int exp_g [3] = '{1, 2, 1};
        int exp_v [5] = '{1, 1, 1, 1, 0};

        req_i = '0;
        req_port_i = '0;
        credit_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        @(negedge clk);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_err", 32'(credit_err_o), 32'd0);
        for (int p = 0; p < PORT_NUM; p++) check("rst_credit", 32'(dut.r_credit[p]), 32'd4);

        // Single request, zero latency
        next_cycle();
        req_i[1][0] = 1'b1;
        req_port_i[1][0] = port_t'(3);
        @(negedge clk);
        check("single_grant1", 32'(grant_o[1]), 32'b01);
        check("single_valid", 32'(valid_o), 32'b01000);
        check("single_sel3", 32'(input_vc_sel_o[3]), 32'd1);
        next_cycle();
        req_i = '0;
        check("single_credit_dut", 32'(dut.r_credit[3]), 32'd3);
        check("single_credit_model", 32'(m_credit[3]), 32'd3);
        credit_i[3] = 1'b1;
        next_cycle();
        credit_i = '0;
        check("single_credit_back", 32'(dut.r_credit[3]), 32'd4);

        // Three inputs contend for port 1, credit returned every cycle
        req_i[0][0] = 1'b1; req_port_i[0][0] = port_t'(1);
        req_i[2][0] = 1'b1; req_port_i[2][0] = port_t'(1);
        req_i[4][0] = 1'b1; req_port_i[4][0] = port_t'(1);
        credit_i[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("contend_sel", 32'(input_vc_sel_o[1]), 32'(exp_w[c]));
            check("contend_valid", 32'(valid_o[1]), 32'd1);
            next_cycle();
        end
        req_i = '0;
        credit_i = '0;
        req_port_i = '0;

        // VC fairness on input 2
        do_reset();
        req_i[2] = 2'b11;
        req_port_i[2][0] = port_t'(0);
        req_port_i[2][1] = port_t'(4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("vc_fair_grant2", 32'(grant_o[2]), 32'(exp_g[c]));
            next_cycle();
        end
        req_i = '0;
        req_port_i = '0;

        // Credit exhaustion on port 0
        do_reset();
        req_i[0][0] = 1'b1;
        req_port_i[0][0] = port_t'(0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("exhaust_valid0", 32'(valid_o[0]), 32'(exp_v[c]));
            next_cycle();
        end
        credit_i[0] = 1'b1;
        @(negedge clk);
        check("exhaust_no_bypass", 32'(valid_o[0]), 32'd0);
        next_cycle();
        credit_i = '0;
        @(negedge clk);
        check("exhaust_regrant", 32'(valid_o[0]), 32'd1);
        check("exhaust_grant0", 32'(grant_o[0]), 32'b01);
        next_cycle();
        req_i = '0;
        req_port_i = '0;

        // Grant and credit together, then credit at full count
        do_reset();
        req_i[3][1] = 1'b1;
        req_port_i[3][1] = port_t'(2);
        credit_i[2] = 1'b1;
        @(negedge clk);
        check("edge_valid2", 32'(valid_o[2]), 32'd1);
        check("edge_grant3", 32'(grant_o[3]), 32'b10);
        next_cycle();
        req_i = '0;
        check("edge_credit_same", 32'(dut.r_credit[2]), 32'd4);
        check("edge_err_clear", 32'(credit_err_o), 32'd0);
        next_cycle();
        credit_i = '0;
        check("edge_err_set", 32'(credit_err_o), 32'd1);
        check("edge_credit_sat", 32'(dut.r_credit[2]), 32'd4);
        next_cycle();
        check("edge_err_sticky", 32'(credit_err_o), 32'd1);

        // Reset raised mid-traffic
        req_i[0][0] = 1'b1;
        req_port_i[0][0] = port_t'(1);
        @(negedge clk);
        check("midrst_before", 32'(valid_o[1]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_grant", 32'(grant_o), 32'd0);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_err", 32'(credit_err_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        req_i = '0;
        req_port_i = '0;
        repeat (2) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
